// File: rtl/mmac_pkg.sv
// ---------------------------------------------------------------------------
// mmac_pkg
// Shared constants and types for the matrix multiply/accumulate datapath.
// The operand loader and its tile buffers take their default widths from
// here so every stage agrees on element and tile sizes.
//
// Contents:
//   VAR_WIDTH      element width in bits
//   M_SIZE         matrix dimension (only 4 is supported)
//   ELEM_PER_TILE  elements per square tile
//   DATA_WIDTH     packed tile width
//   loader_state_t operand loader FSM states
// ---------------------------------------------------------------------------
package mmac_pkg;

    localparam int VAR_WIDTH     = 8;
    localparam int M_SIZE        = 4;
    localparam int ELEM_PER_TILE = M_SIZE * M_SIZE;
    localparam int DATA_WIDTH    = M_SIZE * M_SIZE * VAR_WIDTH;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ISSUE  = 2'd2
    } loader_state_t;

endpackage : mmac_pkg

// File: rtl/mmac_tile_buffer.sv
// ---------------------------------------------------------------------------
// mmac_tile_buffer
// Register file holding one square tile, written one element at a time and
// read out as a single packed row-major word. Slot 0 is element (0,0) and
// lands in the most significant bits of the packed word.
//
// Ports:
//   clock       in   clock
//   reset       in   synchronous, active-low; clears every slot to 0
//   write_en    in   write write_data into slot write_idx this cycle
//   write_idx   in   slot index, row-major (r*M_SIZE + c)
//   write_data  in   element value
//   tile        out  packed tile, slot i at [DATA_WIDTH-1-i*VAR_WIDTH -: VAR_WIDTH]
// ---------------------------------------------------------------------------
module mmac_tile_buffer #(
    parameter int VAR_WIDTH  = mmac_pkg::VAR_WIDTH,
    parameter int ENTRIES    = mmac_pkg::ELEM_PER_TILE,
    parameter int IDX_WIDTH  = $clog2(ENTRIES),
    parameter int DATA_WIDTH = ENTRIES * VAR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [IDX_WIDTH-1:0]  write_idx,
    input  logic [VAR_WIDTH-1:0]  write_data,
    output logic [DATA_WIDTH-1:0] tile
);

    logic [VAR_WIDTH-1:0] slots [ENTRIES];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slots[i] <= '0;
            end
        end else if (write_en) begin
            slots[write_idx] <= write_data;
        end
    end

    // Row-major packing: lower slot index goes to higher bit positions.
    always_comb begin
        tile = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            tile[DATA_WIDTH-1-i*VAR_WIDTH -: VAR_WIDTH] = slots[i];
        end
    end

endmodule : mmac_tile_buffer

// File: rtl/mmac_operand_loader.sv
// ---------------------------------------------------------------------------
// mmac_operand_loader
// Upstream stage of the matrix multiply/accumulate datapath. Collects a
// serial element stream (A(0,0)..A(3,3) then B(0,0)..B(3,3)) over a
// valid/ready handshake, then presents both tiles packed to the multiply
// unit and raises the accumulate strobes when the tiles are taken.
//
// Ports:
//   clock       in   clock
//   reset       in   synchronous, active-low
//   in_valid    in   element valid
//   in_ready    out  loader can accept an element (low in ISSUE and in reset)
//   in_data     in   element value
//   in_first    in   first A element of an accumulation group
//   out_valid   out  packed A/B tiles are valid
//   out_ready   in   consumer takes the tiles
//   matrixA     out  packed A tile, row-major, (0,0) in the MSBs
//   matrixB     out  packed B tile, row-major, (0,0) in the MSBs
//   acc_clear   out  one-cycle strobe: clear the accumulator
//   acc_enable  out  one-cycle strobe: accumulate the current product
//   tile_count  out  (MMAC_LOADER_PERF_EN only) tile handshakes, wrapping
//   stall_count out  (MMAC_LOADER_PERF_EN only) out_valid && !out_ready
//                    cycles, saturating
//
// Build option: define MMAC_LOADER_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module mmac_operand_loader #(
    parameter int VAR_WIDTH  = mmac_pkg::VAR_WIDTH,
    parameter int M_SIZE     = mmac_pkg::M_SIZE,
    parameter int DATA_WIDTH = M_SIZE * M_SIZE * VAR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VAR_WIDTH-1:0]  in_data,
    input  logic                  in_first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] matrixA,
    output logic [DATA_WIDTH-1:0] matrixB,
    output logic                  acc_clear,
    output logic                  acc_enable
`ifdef MMAC_LOADER_PERF_EN
    ,
    output logic [15:0]           tile_count,
    output logic [15:0]           stall_count
`endif
);

    import mmac_pkg::*;

    localparam int SLOTS = M_SIZE * M_SIZE;
    localparam logic [3:0] LAST_IDX = 4'(SLOTS - 1);

    loader_state_t state;
    logic [3:0]    elem_cnt;
    logic          grp_first;

    logic elem_xfer;
    logic tile_xfer;
    logic write_a;
    logic write_b;

    // Handshake outputs are gated by reset so nothing is accepted or offered
    // while reset is held, even in the first reset cycle before the state
    // register has returned to LOAD_A.
    always_comb begin
        in_ready  = reset && (state != ISSUE);
        out_valid = reset && (state == ISSUE);
    end

    always_comb begin
        elem_xfer  = in_valid && in_ready;
        tile_xfer  = out_valid && out_ready;
        write_a    = elem_xfer && (state == LOAD_A);
        write_b    = elem_xfer && (state == LOAD_B);
        acc_enable = tile_xfer;
        acc_clear  = tile_xfer && grp_first;
    end

    // elem_cnt is 4 bits wide so it wraps from 15 to 0 on its own when the
    // last element of a tile is taken; only the state needs steering.
    // grp_first is captured solely on the very first A element of a pair.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= LOAD_A;
            elem_cnt  <= 4'd0;
            grp_first <= 1'b0;
        end else begin
            unique case (state)
                LOAD_A: begin
                    if (elem_xfer) begin
                        if (elem_cnt == 4'd0) begin
                            grp_first <= in_first;
                        end
                        elem_cnt <= elem_cnt + 4'd1;
                        if (elem_cnt == LAST_IDX) begin
                            state <= LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (elem_xfer) begin
                        elem_cnt <= elem_cnt + 4'd1;
                        if (elem_cnt == LAST_IDX) begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (tile_xfer) begin
                        state <= LOAD_A;
                    end
                end
                default: begin
                    state    <= LOAD_A;
                    elem_cnt <= 4'd0;
                end
            endcase
        end
    end

    mmac_tile_buffer #(
        .VAR_WIDTH  (VAR_WIDTH),
        .ENTRIES    (SLOTS),
        .IDX_WIDTH  (4),
        .DATA_WIDTH (DATA_WIDTH)
    ) tile_a (
        .clock      (clock),
        .reset      (reset),
        .write_en   (write_a),
        .write_idx  (elem_cnt),
        .write_data (in_data),
        .tile       (matrixA)
    );

    mmac_tile_buffer #(
        .VAR_WIDTH  (VAR_WIDTH),
        .ENTRIES    (SLOTS),
        .IDX_WIDTH  (4),
        .DATA_WIDTH (DATA_WIDTH)
    ) tile_b (
        .clock      (clock),
        .reset      (reset),
        .write_en   (write_b),
        .write_idx  (elem_cnt),
        .write_data (in_data),
        .tile       (matrixB)
    );

`ifdef MMAC_LOADER_PERF_EN
    // tile_count wraps naturally at 16 bits; stall_count stops at all-ones
    // so a long stall never reads back as a short one.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tile_count  <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            if (tile_xfer) begin
                tile_count <= tile_count + 16'd1;
            end
            if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule : mmac_operand_loader

// File: doc/mmac_operand_loader.md
Name: mmac_operand_loader

Overview:
- Upstream stage of the matrix multiply/accumulate datapath.
- Accepts a serial element stream with a valid/ready handshake and assembles one 4x4 A tile, then one 4x4 B tile.
- Presents both tiles as packed words to the multiply unit and generates the accumulate-control strobes for the accumulate unit.
- Decouples the element-at-a-time memory/DMA side from the tile-at-a-time MAC side.

Parameters:
- VAR_WIDTH, 8, element width in bits (mirrors the mmac_pkg constant).
- M_SIZE, 4, matrix dimension. Only 4 is supported.
- DATA_WIDTH, M_SIZE*M_SIZE*VAR_WIDTH, packed tile width.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  1  element valid.
- in_ready  out  1  loader can accept an element.
- in_data  in  VAR_WIDTH  element value.
- in_first  in  1  marks the first A element of an accumulation group.
- out_valid  out  1  packed A/B tiles are valid.
- out_ready  in  1  consumer takes the tiles.
- matrixA  out  DATA_WIDTH  packed A tile.
- matrixB  out  DATA_WIDTH  packed B tile.
- acc_clear  out  1  one-cycle strobe: clear the accumulator.
- acc_enable  out  1  one-cycle strobe: accumulate the current product.

Behaviour:
- Handshakes: an element transfer occurs when in_valid && in_ready. A tile transfer occurs when out_valid && out_ready.
- Packing is row-major. Element (r,c) occupies bits [DATA_WIDTH-1-(r*4+c)*VAR_WIDTH -: VAR_WIDTH], so element (0,0) sits in the MSBs. The stream order is A(0,0)..A(3,3), then B(0,0)..B(3,3).
- FSM states:
  - LOAD_A: in_ready=1. Each transfer writes slot elem_cnt of A and increments elem_cnt (4-bit, 0..15). When a transfer occurs at elem_cnt==15, elem_cnt wraps to 0 and the FSM moves to LOAD_B.
  - LOAD_B: same as LOAD_A, but writes B. A transfer at elem_cnt==15 moves the FSM to ISSUE.
  - ISSUE: in_ready=0, out_valid=1. matrixA/matrixB are held stable until out_ready. When a tile transfer occurs, the FSM returns to LOAD_A.
- in_first is sampled only on the transfer at LOAD_A with elem_cnt==0; it is ignored at all other times. The sampled value is stored in grp_first.
- Latency: the last B element is accepted in cycle N, and out_valid is high in cycle N+1. The minimum period is 33 cycles per tile pair.
- Accumulate strobes are combinational from the tile handshake:
  - acc_enable = out_valid && out_ready.
  - acc_clear = out_valid && out_ready && grp_first.
- in_valid low mid-load: elem_cnt holds and no slot is written.
- out_ready high while the FSM is not in ISSUE: no effect.
- out_ready may stay high continuously. Each tile pair still yields exactly one acc_enable pulse.
- Reset values (while reset==0):
  - FSM goes to LOAD_A; elem_cnt=0; grp_first=0.
  - Outputs: out_valid=0, acc_clear=0, acc_enable=0, in_ready=0 during reset.
  - matrixA and matrixB storage is cleared to 0.
- Reset mid-load or mid-ISSUE discards the partial or pending tiles and produces no strobes.
- No arithmetic is performed. Values pass through bit-exact.

Optional Feature:
- Macro: MMAC_LOADER_PERF_EN.
- When defined:
  - Adds output tile_count (16 bits). It increments on each tile handshake, wraps at 0xFFFF->0, and resets to 0.
  - Adds output stall_count (16 bits). It counts cycles with out_valid && !out_ready, saturates at 0xFFFF, and resets to 0.
- When undefined: neither port nor counter exists. The behaviour of all other ports is identical.

Decomposition:
- mmac_pkg receives:
  - loader_state_t enum {LOAD_A, LOAD_B, ISSUE};
  - the ELEM_PER_TILE constant (= M_SIZE*M_SIZE);
  - DATA_WIDTH, defined as M_SIZE*M_SIZE*VAR_WIDTH.
- One sub-module: mmac_tile_buffer. It is a 16-entry VAR_WIDTH register file with write-enable and index inputs and a packed row-major read-out. It is instantiated twice, once for A and once for B.

Test Plan:
- Stream A=1..16 and B=17..32, with in_valid=1, in_first=1 and out_ready=1 throughout -> out_valid rises exactly 1 cycle after element 32. matrixA MSB byte is 0x01 and LSB byte is 0x10; matrixB MSB byte is 0x11 and LSB byte is 0x20. acc_clear=acc_enable=1 for one cycle.
- Hold out_ready=0 for 5 cycles in ISSUE -> out_valid stays 1, in_ready stays 0, tiles stay stable, no strobes. Raise out_ready -> single acc_enable pulse, then LOAD_A.
- Send two consecutive tile pairs with in_first=1 then 0 -> pair 1 gives acc_clear=1 with acc_enable. Pair 2 gives acc_enable=1 with acc_clear=0.
- Random in_valid bubbles (~50%) -> tiles match a reference packing model. Exactly 32 element transfers per issue.
- Assert reset after 20 elements, release, then send a full pair of 7s -> no out_valid before the 32nd new element. Both tiles contain all 0x07.
- With MMAC_LOADER_PERF_EN: 3 issues with 4 stall cycles total -> tile_count=3, stall_count=4.
